// File: rtl/led_pkg.sv
// Shared types and constants for the LED rate controller and its button front end.
package led_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  localparam logic [1:0] RATE_BASE    = 2'd0;
  localparam logic [1:0] RATE_HALF    = 2'd1;
  localparam logic [1:0] RATE_QUARTER = 2'd2;
  localparam logic [1:0] RATE_SLOW    = 2'd3;

  // Tick period in clock cycles for a rate index, derived from the rate-0 period.
  function automatic int unsigned rate_period(input logic [1:0] rate, input int unsigned base);
    case (rate)
      RATE_BASE:    rate_period = base;
      RATE_HALF:    rate_period = base / 32'd2;
      RATE_QUARTER: rate_period = base / 32'd4;
      RATE_SLOW:    rate_period = base * 32'd2;
      default:      rate_period = base;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus a four-state debounce FSM for one raw push button.
// Produces the debounced level and a single-cycle pulse on each accepted press.
module btn_debounce
  import led_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);

  logic [1:0]      sync_q;
  logic            btn_sync_s;
  db_state_e       state_q;
  logic [DB_W-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign btn_sync_s = sync_q[1];

  // The counter restarts on every state change so each wait measures an unbroken run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= DB_ZERO;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (btn_sync_s) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= DB_ZERO;
          end
        end
        WAIT_HIGH: begin
          if (!btn_sync_s) begin
            state_q <= LOW;
            cnt_q   <= DB_ZERO;
          end else if (cnt_q == DB_LAST) begin
            state_q <= HIGH;
            cnt_q   <= DB_ZERO;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DB_ONE;
          end
        end
        HIGH: begin
          if (!btn_sync_s) begin
            state_q <= WAIT_LOW;
            cnt_q   <= DB_ZERO;
          end
        end
        WAIT_LOW: begin
          if (btn_sync_s) begin
            state_q <= HIGH;
            cnt_q   <= DB_ZERO;
          end else if (cnt_q == DB_LAST) begin
            state_q <= LOW;
            cnt_q   <= DB_ZERO;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + DB_ONE;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= DB_ZERO;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/led_rate_ctrl.sv
// Selectable-rate tick generator for an LED blinker; each debounced button press
// advances the rate index, which restarts the current period from zero.
module led_rate_ctrl
  import led_pkg::*;
#(
  parameter int BASE_CYCLES = 50_000_000,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       en,
  input  logic       btn,
  output logic       tick,
  output logic [1:0] rate_sel,
  output logic       btn_pulse
);

  localparam int CNT_W = $clog2(2 * BASE_CYCLES);
  localparam int unsigned P_BASE    = rate_period(RATE_BASE, BASE_CYCLES);
  localparam int unsigned P_HALF    = rate_period(RATE_HALF, BASE_CYCLES);
  localparam int unsigned P_QUARTER = rate_period(RATE_QUARTER, BASE_CYCLES);
  localparam int unsigned P_SLOW    = rate_period(RATE_SLOW, BASE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_BASE    = CNT_W'(P_BASE - 1);
  localparam logic [CNT_W-1:0] LAST_HALF    = CNT_W'(P_HALF - 1);
  localparam logic [CNT_W-1:0] LAST_QUARTER = CNT_W'(P_QUARTER - 1);
  localparam logic [CNT_W-1:0] LAST_SLOW    = CNT_W'(P_SLOW - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic             rise_s;
  logic             btn_level_unused_s;
  logic [CNT_W-1:0] last_s;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             tick_d, tick_q;
  logic [1:0]       rate_sel_d, rate_sel_q;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk    (CLK),
    .rst_n  (rst_n),
    .btn_raw(btn),
    .level  (btn_level_unused_s),
    .rise   (rise_s)
  );

  always_comb begin
    last_s = LAST_BASE;
    case (rate_sel_q)
      RATE_BASE:    last_s = LAST_BASE;
      RATE_HALF:    last_s = LAST_HALF;
      RATE_QUARTER: last_s = LAST_QUARTER;
      RATE_SLOW:    last_s = LAST_SLOW;
      default:      last_s = LAST_BASE;
    endcase
  end

  // A rate change outranks the terminal count so the new period starts cleanly.
  always_comb begin
    rate_sel_d = rate_sel_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    if (rise_s) begin
      rate_sel_d = rate_sel_q + 2'd1;
    end else begin
      rate_sel_d = rate_sel_q;
    end
    if (!en) begin
      cnt_d  = CNT_ZERO;
      tick_d = 1'b0;
    end else if (rise_s) begin
      cnt_d  = CNT_ZERO;
      tick_d = 1'b0;
    end else if (cnt_q == last_s) begin
      cnt_d  = CNT_ZERO;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_ONE;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= CNT_ZERO;
      tick_q     <= 1'b0;
      rate_sel_q <= RATE_BASE;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      rate_sel_q <= rate_sel_d;
    end
  end

  assign tick      = tick_q;
  assign rate_sel  = rate_sel_q;
  assign btn_pulse = rise_s;

endmodule

// File: tb/tb_led_rate_ctrl.sv
// Directed bench for led_rate_ctrl with BASE_CYCLES=16 and DB_CYCLES=4.
module tb_led_rate_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       en;
  logic       btn;
  logic       tick;
  logic [1:0] rate_sel;
  logic       btn_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  led_rate_ctrl #(
    .BASE_CYCLES(16),
    .DB_CYCLES  (4)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .en       (en),
    .btn      (btn),
    .tick     (tick),
    .rate_sel (rate_sel),
    .btn_pulse(btn_pulse)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input logic [31:0] observed, input logic [31:0] expected, input string tag);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Steps until tick is seen; the number of steps taken must equal the expected period.
  task automatic wait_tick(input int expected, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < expected + 8);
    check(32'(n), 32'(expected), tag);
  endtask

  // Holds btn for 6 cycles; pulse is due 7 cycles after btn rises, rate change one later.
  task automatic press(input logic [1:0] exp_rate, input int exp_period, input string tag);
    int n;
    n = 0;
    btn = 1'b1;
    do begin
      step();
      n++;
      if (n == 6) btn = 1'b0;
    end while (btn_pulse !== 1'b1 && n < 20);
    btn = 1'b0;
    check(32'(n), 32'd7, {tag, " pulse latency"});
    step();
    check(32'(rate_sel), 32'(exp_rate), {tag, " rate_sel"});
    check(32'(tick), 32'd0, {tag, " tick at rate change"});
    check(32'(btn_pulse), 32'd0, {tag, " pulse width"});
    wait_tick(exp_period, {tag, " first period"});
    wait_tick(exp_period, {tag, " second period"});
  endtask

  initial begin
    int pulses;
    int ticks;

    rst_n = 1'b0;
    en    = 1'b0;
    btn   = 1'b0;
    #2;
    check(32'(tick), 32'd0, "reset tick");
    check(32'(rate_sel), 32'd0, "reset rate_sel");
    check(32'(btn_pulse), 32'd0, "reset btn_pulse");
    repeat (3) step();

    rst_n = 1'b1;
    en    = 1'b1;
    wait_tick(16, "tick 16");
    step();
    check(32'(tick), 32'd0, "tick single cycle");
    wait_tick(15, "tick 32");
    wait_tick(16, "tick 48");
    check(32'(rate_sel), 32'd0, "rate_sel stays 0");

    // Short press: too brief to be accepted.
    pulses = 0;
    btn = 1'b1;
    repeat (3) begin
      step();
      if (btn_pulse === 1'b1) pulses++;
    end
    btn = 1'b0;
    repeat (15) begin
      step();
      if (btn_pulse === 1'b1) pulses++;
    end
    check(32'(pulses), 32'd0, "short press pulses");
    check(32'(rate_sel), 32'd0, "short press rate_sel");

    press(2'd1, 8, "press1");
    press(2'd2, 4, "press2");
    press(2'd3, 32, "press3");
    press(2'd0, 16, "press4");

    // Acceptance lands on the edge where the rate-0 count sits at 15.
    repeat (8) step();
    press(2'd1, 8, "press at terminal");

    press(2'd2, 4, "press to rate2");

    // Reset mid-period and mid-debounce.
    btn = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    btn   = 1'b0;
    #2;
    check(32'(tick), 32'd0, "async reset tick");
    check(32'(rate_sel), 32'd0, "async reset rate_sel");
    check(32'(btn_pulse), 32'd0, "async reset btn_pulse");
    repeat (2) step();
    rst_n = 1'b1;
    wait_tick(16, "tick after reset");
    check(32'(rate_sel), 32'd0, "rate_sel after reset");

    // Drop en at count 10, hold it low for 5 cycles.
    repeat (10) step();
    en    = 1'b0;
    ticks = 0;
    repeat (5) begin
      step();
      if (tick === 1'b1) ticks++;
    end
    check(32'(ticks), 32'd0, "ticks while en low");
    en = 1'b1;
    wait_tick(16, "tick after en rise");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
